div_unit: RTL and testbench

- Iterative radix-2 integer divider in the EXU. It implements RV32M DIV/DIVU/REM/REMU.
- It uses the same idu1_out_t control input and the same write-back and tag output interface as the pipelined multiply/accumulate unit.
- It is the inverse-arithmetic unit next to that multiplier. The issue logic stalls on div_busy.

---
 rtl/div_unit_pkg.sv | 45 ++++
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_div_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg : shared decode struct, divider state type and RV32M funct3 codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_unit_pkg;

  localparam int unsigned DIV_XLEN = 32;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic [DIV_XLEN-1:0] rs1_data;
    logic [DIV_XLEN-1:0] rs2_data;
    logic [4:0]          rd_addr;
    logic [31:0]         instr;
    logic [DIV_XLEN-1:0] instr_tag;
    logic                div;
    logic                legal;
    logic                nop;
  } idu1_out_t;

  // One extra bit so that the magnitude of the most negative value is exact.
  function automatic logic [DIV_XLEN:0] div_mag(input logic [DIV_XLEN-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[DIV_XLEN-1])
      div_mag = {1'b0, ~v} + {{DIV_XLEN{1'b0}}, 1'b1};
    else
      div_mag = {1'b0, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step : one combinational restoring-division iteration
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN:0]   divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic          ge;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    ge      = (shifted >= divisor_i);
    // The partial remainder stays below the divisor, so XLEN bits always hold it.
    rem_o   = ge ? XLEN'(shifted - divisor_i) : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], ge};
  end

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU); DIV_EARLY_OUT_EN
// enables a 1-cycle result when |rs1| < |rs2|.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  idu1_out_t       div_ctrl,
  output logic [XLEN-1:0] out,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wr_en,
  output logic [XLEN-1:0] instr_tag_out,
  output logic [31:0]     instr_out,
  output logic            div_busy
);

  localparam int unsigned    CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN:0]     dvs_q, dvs_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              wr_en_q, wr_en_d;
  logic [XLEN-1:0]   out_tag_q, out_tag_d;
  logic [31:0]       out_instr_q, out_instr_d;

  logic              launch;
  logic [2:0]        l_op;
  logic              l_signed;
  logic              l_rem;
  logic [XLEN:0]     l_mag1;
  logic [XLEN:0]     l_mag2;
  logic              l_zero;
  logic              l_ovf;
  logic              l_fast;
  logic [XLEN-1:0]   step_rem;
  logic [XLEN-1:0]   step_quo;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign launch   = div_ctrl.div & div_ctrl.legal & ~div_ctrl.nop & ~freeze &
                    ((state_q == IDLE) | (state_q == DONE));
  assign l_op     = div_ctrl.instr[14:12];
  assign l_signed = ~l_op[0];
  assign l_rem    = l_op[1];
  assign l_mag1   = div_mag(div_ctrl.rs1_data, l_signed);
  assign l_mag2   = div_mag(div_ctrl.rs2_data, l_signed);
  assign l_zero   = (div_ctrl.rs2_data == '0);
  assign l_ovf    = l_signed & (div_ctrl.rs1_data == INT_MIN) & (div_ctrl.rs2_data == '1);
  assign quo_fix  = neg_quo_q ? ({XLEN{1'b0}} - quo_q) : quo_q;
  assign rem_fix  = neg_rem_q ? ({XLEN{1'b0}} - rem_q) : rem_q;
  assign div_busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    is_rem_d    = is_rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    rd_d        = rd_q;
    instr_d     = instr_q;
    tag_d       = tag_q;
    out_d       = '0;
    out_rd_d    = '0;
    wr_en_d     = 1'b0;
    out_tag_d   = '0;
    out_instr_d = '0;
    l_fast      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (launch) begin
          is_rem_d  = l_rem;
          neg_quo_d = l_signed & (div_ctrl.rs1_data[XLEN-1] ^ div_ctrl.rs2_data[XLEN-1]);
          neg_rem_d = l_signed & div_ctrl.rs1_data[XLEN-1];
          rd_d      = div_ctrl.rd_addr;
          instr_d   = div_ctrl.instr;
          tag_d     = div_ctrl.instr_tag;
          if (l_zero) begin
            l_fast = 1'b1;
            out_d  = l_rem ? div_ctrl.rs1_data : '1;
          end else if (l_ovf) begin
            l_fast = 1'b1;
            out_d  = l_rem ? '0 : INT_MIN;
`ifdef DIV_EARLY_OUT_EN
          end else if (l_mag1 < l_mag2) begin
            l_fast = 1'b1;
            out_d  = l_rem ? div_ctrl.rs1_data : '0;
`endif
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(XLEN - 1);
            rem_d   = '0;
            quo_d   = XLEN'(l_mag1);
            dvs_d   = l_mag2;
          end
          if (l_fast) begin
            state_d     = DONE;
            wr_en_d     = 1'b1;
            out_rd_d    = div_ctrl.rd_addr;
            out_tag_d   = div_ctrl.instr_tag;
            out_instr_d = div_ctrl.instr;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0)
          state_d = FIX;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        state_d     = DONE;
        out_d       = is_rem_q ? rem_fix : quo_fix;
        wr_en_d     = 1'b1;
        out_rd_d    = rd_q;
        out_tag_d   = tag_q;
        out_instr_d = instr_q;
      end
    endcase
  end

  // Freeze gates every register, so the DONE strobe and its payload simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      is_rem_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      rd_q        <= '0;
      instr_q     <= '0;
      tag_q       <= '0;
      out_q       <= '0;
      out_rd_q    <= '0;
      wr_en_q     <= 1'b0;
      out_tag_q   <= '0;
      out_instr_q <= '0;
    end else if (!freeze) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      is_rem_q    <= is_rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      rd_q        <= rd_d;
      instr_q     <= instr_d;
      tag_q       <= tag_d;
      out_q       <= out_d;
      out_rd_q    <= out_rd_d;
      wr_en_q     <= wr_en_d;
      out_tag_q   <= out_tag_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign out           = out_q;
  assign out_rd_addr   = out_rd_q;
  assign out_rd_wr_en  = wr_en_q;
  assign instr_tag_out = out_tag_q;
  assign instr_out     = out_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit : directed + randomized self-checking bench for div_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN       = 32;
  localparam int LAT_NORMAL = XLEN + 2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        freeze = 1'b0;
  idu1_out_t   div_ctrl;
  logic [31:0] out;
  logic [4:0]  out_rd_addr;
  logic        out_rd_wr_en;
  logic [31:0] instr_tag_out;
  logic [31:0] instr_out;
  logic        div_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .freeze        (freeze),
    .div_ctrl      (div_ctrl),
    .out           (out),
    .out_rd_addr   (out_rd_addr),
    .out_rd_wr_en  (out_rd_wr_en),
    .instr_tag_out (instr_tag_out),
    .instr_out     (instr_out),
    .div_busy      (div_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // RV32M result rules in plain integer arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
    int sa;
    int sb;
    bit ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (f3 == 3'b100) begin
      if (b == 0) return 32'hFFFF_FFFF;
      if (ovf) return 32'h8000_0000;
      return 32'(sa / sb);
    end else if (f3 == 3'b101) begin
      if (b == 0) return 32'hFFFF_FFFF;
      return a / b;
    end else if (f3 == 3'b110) begin
      if (b == 0) return a;
      if (ovf) return 32'h0;
      return 32'(sa % sb);
    end
    if (b == 0) return a;
    return a % b;
  endfunction

  function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    bit sgn;
    sgn = !f3[0];
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    begin
      longint ma;
      longint mb;
      if (sgn) begin
        ma = longint'(int'(a));
        mb = longint'(int'(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
      end else begin
        ma = longint'(a);
        mb = longint'(b);
      end
      if (ma < mb) return 1;
    end
`endif
    return LAT_NORMAL;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] tag);
    div_ctrl           = '0;
    div_ctrl.rs1_data  = a;
    div_ctrl.rs2_data  = b;
    div_ctrl.rd_addr   = rd;
    div_ctrl.instr     = {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    div_ctrl.instr_tag = tag;
    div_ctrl.div       = 1'b1;
    div_ctrl.legal     = 1'b1;
    div_ctrl.nop       = 1'b0;
    @(posedge clk);
    #1;
    div_ctrl.div = 1'b0;
  endtask

  // Launches one op, waits for its strobe and checks payload, latency and busy.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] tag,
                       input int fz_at, input int fz_len);
    int          n;
    int          busy_n;
    int          e_lat;
    bit          seen;
    bit          stable;
    logic [33:0] snap;
    logic [31:0] e_out;
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    stable = 1'b1;
    snap   = '0;
    e_out  = model_result(f3, a, b);
    e_lat  = model_latency(f3, a, b) + fz_len;
    issue(f3, a, b, rd, tag);
    while (!seen && n < 120) begin
      @(negedge clk);
      n++;
      if (fz_len > 0 && n > fz_at && n <= fz_at + fz_len &&
          snap !== {out_rd_wr_en, div_busy, out})
        stable = 1'b0;
      if (fz_len > 0 && n == fz_at) begin
        snap   = {out_rd_wr_en, div_busy, out};
        freeze = 1'b1;
      end
      if (fz_len > 0 && n == fz_at + fz_len) freeze = 1'b0;
      if (out_rd_wr_en) seen = 1'b1;
      else if (div_busy) busy_n++;
    end
    freeze = 1'b0;
    chk({name, "_strobe"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'(e_lat));
    chk({name, "_out"}, out, e_out);
    chk({name, "_rd"}, 32'(out_rd_addr), 32'(rd));
    chk({name, "_tag"}, instr_tag_out, tag);
    chk({name, "_instr"}, instr_out, {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011});
    chk({name, "_busy_cycles"}, 32'(busy_n), 32'(e_lat - 1));
    chk({name, "_busy_at_done"}, 32'(div_busy), 32'd1);
    if (fz_len > 0) chk({name, "_freeze_stable"}, 32'(stable), 32'd1);
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    chk({name, "_strobe_drop"}, 32'(out_rd_wr_en), 32'd0);
    chk({name, "_out_zero"}, out, 32'd0);
    chk({name, "_idle"}, 32'(div_busy), 32'd0);
  endtask

  initial begin
    int          strobes;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    div_ctrl = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", out, 32'd0);
    chk("reset_wr", 32'(out_rd_wr_en), 32'd0);
    chk("reset_busy", 32'(div_busy), 32'd0);
    chk("reset_tag", instr_tag_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("div_100_7", FUNCT3_DIV, 32'd100, 32'd7, 5'd5, 32'h11, 0, 0);
    idle_check("div_100_7");
    do_op("rem_100_7", FUNCT3_REM, 32'd100, 32'd7, 5'd6, 32'h12, 0, 0);
    idle_check("rem_100_7");
    do_op("div_m7_2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h13, 0, 0);
    idle_check("div_m7_2");
    do_op("rem_m7_2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h14, 0, 0);
    idle_check("rem_m7_2");
    do_op("remu_big_2", FUNCT3_REMU, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h15, 0, 0);
    idle_check("remu_big_2");
    do_op("divu_5_0", FUNCT3_DIVU, 32'd5, 32'd0, 5'd10, 32'h16, 0, 0);
    idle_check("divu_5_0");
    do_op("remu_5_0", FUNCT3_REMU, 32'd5, 32'd0, 5'd11, 32'h17, 0, 0);
    idle_check("remu_5_0");
    do_op("div_ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h18, 0, 0);
    idle_check("div_ovf");
    do_op("rem_ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h19, 0, 0);
    idle_check("rem_ovf");
    do_op("divu_frz", FUNCT3_DIVU, 32'd1000, 32'd3, 5'd14, 32'h1A, 10, 5);
    idle_check("divu_frz");
    do_op("divu_3_9", FUNCT3_DIVU, 32'd3, 32'd9, 5'd15, 32'h1B, 0, 0);
    idle_check("divu_3_9");

    // nop-flagged request must not start the unit
    div_ctrl          = '0;
    div_ctrl.div      = 1'b1;
    div_ctrl.legal    = 1'b1;
    div_ctrl.nop      = 1'b1;
    div_ctrl.rs1_data = 32'd50;
    div_ctrl.rs2_data = 32'd5;
    @(posedge clk);
    #1;
    div_ctrl = '0;
    chk("nop_ignored", 32'(div_busy), 32'd0);
    @(negedge clk);

    // back-to-back: second launch presented in the first op's DONE cycle
    do_op("b2b_first", FUNCT3_DIV, 32'd100, 32'd7, 5'd20, 32'hA1, 0, 0);
    do_op("b2b_second", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd21, 32'hA2, 0, 0);
    idle_check("b2b");

    // reset in the middle of an iteration
    issue(FUNCT3_DIVU, 32'd1000, 32'd7, 5'd22, 32'hDEAD);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(div_busy), 32'd0);
    chk("rst_mid_out", out, 32'd0);
    chk("rst_mid_wr", 32'(out_rd_wr_en), 32'd0);
    chk("rst_mid_rd", 32'(out_rd_addr), 32'd0);
    chk("rst_mid_tag", instr_tag_out, 32'd0);
    chk("rst_mid_instr", instr_out, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    strobes = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_rd_wr_en) strobes++;
    end
    chk("rst_no_strobe", 32'(strobes), 32'd0);
    do_op("post_rst_divu", FUNCT3_DIVU, 32'd9, 32'd3, 5'd23, 32'hB0, 0, 0);
    idle_check("post_rst");

    for (int i = 0; i < 24; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'($urandom_range(0, 100)); b = 32'($urandom_range(101, 1000)); end
        3: begin a = 32'h8000_0000; b = (i % 2 == 0) ? 32'hFFFF_FFFF : b; end
        default: ;
      endcase
      do_op("rand", f3, a, b, 5'($urandom), $urandom, 0, 0);
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
    idle_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
